// File: rtl/fifo_axis_tx.sv
// fifo_axis_tx
// Drains a first-word-fall-through FIFO and presents its words as an
// AXI4-Stream master. A two-entry buffer (main + skid) sustains one beat per
// cycle while keeping fifo_deq free of any combinational path from m_tready.
// m_tlast comes from a beat counter at a fixed packet length.
//
// Parameters
//   F_WIDTH  data width (must match the FIFO)
//   PKT_LEN  beats per packet (>= 1)
//   CW       beat counter width
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   fifo_dout   FIFO head word (valid while fifo_empty is 0)
//   fifo_empty  FIFO empty flag
//   fifo_deq    pop request; fifo_dout is captured in the same cycle
//   m_tdata     stream data
//   m_tvalid    stream valid
//   m_tready    stream ready from the consumer
//   m_tlast     last beat of a packet
//   busy        either buffer entry occupied
module fifo_axis_tx #(
  parameter int F_WIDTH = 8,
  parameter int PKT_LEN = 4,
  parameter int CW      = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [F_WIDTH-1:0] fifo_dout,
  input  logic               fifo_empty,
  output logic               fifo_deq,
  output logic [F_WIDTH-1:0] m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(PKT_LEN - 1);

  state_t             state_q, state_d;
  logic [F_WIDTH-1:0] main_data_q, main_data_d;
  logic               main_last_q, main_last_d;
  logic [F_WIDTH-1:0] skid_data_q, skid_data_d;
  logic               skid_last_q, skid_last_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               hs;
  logic               cap_last;

  // Pop decision uses only registered occupancy and fifo_empty, so the
  // consumer's ready never reaches the FIFO combinationally.
  assign fifo_deq = rst & ~fifo_empty & (state_q != S_TWO);
  assign m_tvalid = (state_q != S_EMPTY);
  assign busy     = m_tvalid;
  assign m_tdata  = main_data_q;
  assign m_tlast  = main_last_q;
  assign hs       = m_tvalid & m_tready;

  // Last tag is attached at capture time, from the word's position in FIFO order.
  assign cap_last = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (fifo_deq) begin
      cnt_d = cap_last ? '0 : cnt_q + CW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_last_d = main_last_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    case (state_q)
      S_EMPTY: begin
        if (fifo_deq) begin
          state_d     = S_ONE;
          main_data_d = fifo_dout;
          main_last_d = cap_last;
        end
      end
      S_ONE: begin
        if (hs && fifo_deq) begin
          main_data_d = fifo_dout;
          main_last_d = cap_last;
        end else if (hs) begin
          state_d = S_EMPTY;
        end else if (fifo_deq) begin
          // Consumer stalled: park the already-popped word in the skid entry.
          state_d     = S_TWO;
          skid_data_d = fifo_dout;
          skid_last_d = cap_last;
        end
      end
      S_TWO: begin
        if (hs) begin
          state_d     = S_ONE;
          main_data_d = skid_data_q;
          main_last_d = skid_last_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_EMPTY;
      cnt_q       <= '0;
      main_data_q <= '0;
      main_last_q <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      main_data_q <= main_data_d;
      main_last_q <= main_last_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
    end
  end

endmodule

// File: tb/tb_fifo_axis_tx.sv
`timescale 1ns/1ps
module tb_fifo_axis_tx;
  localparam int W   = 8;
  localparam int PKT = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] fifo_dout = '0;
  logic         fifo_empty = 1'b1;
  logic         fifo_deq;
  logic [W-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic         m_tlast;
  logic         busy;

  // Second instance built with PKT_LEN = 1, fed by a tiny 3-word source.
  logic [W-1:0] dout1 = '0;
  logic         empty1 = 1'b1;
  logic         deq1;
  logic [W-1:0] tdata1;
  logic         tvalid1, tlast1, busy1;

  fifo_axis_tx #(.F_WIDTH(W), .PKT_LEN(PKT)) dut (
    .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_deq(fifo_deq), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy));

  fifo_axis_tx #(.F_WIDTH(W), .PKT_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .fifo_dout(dout1), .fifo_empty(empty1),
    .fifo_deq(deq1), .m_tdata(tdata1), .m_tvalid(tvalid1),
    .m_tready(1'b1), .m_tlast(tlast1), .busy(busy1));

  always #5 clk = ~clk;

  logic [W-1:0] fq[$];    // FIFO contents
  logic [W:0]   exq[$];   // expected beats {last, data}
  int unsigned  idx = 0;  // words pushed since reset
  int           checks = 0;
  int           failures = 0;
  int           occ = 0;  // model buffer occupancy
  int           beats1 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_dout  = fifo_empty ? '0 : fq[0];
  endtask

  task automatic push(input logic [W-1:0] w);
    logic lst;
    lst = ((idx % PKT) == PKT - 1);
    fq.push_back(w);
    exq.push_back({lst, w});
    idx++;
    refresh();
  endtask

  // One clock: inputs were set at posedge+1; the FIFO pops after the edge.
  task automatic step();
    logic deq_s;
    #1;
    deq_s = fifo_deq;
    @(posedge clk);
    #1;
    if (deq_s && fq.size() != 0) void'(fq.pop_front());
    refresh();
  endtask

  task automatic clear_all();
    fq.delete();
    exq.delete();
    idx = 0;
    refresh();
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b0;
    clear_all();
    for (int i = 0; i < cyc; i++) step();
    rst = 1'b1;
  endtask

  // Monitor / scoreboard for the main instance.
  initial begin
    logic         stall;
    logic [W-1:0] pdata;
    logic         plast;
    logic [W:0]   e;
    logic         mhs;
    stall = 1'b0; pdata = '0; plast = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_tvalid", 32'(m_tvalid), 0);
        chk("rst_tdata",  32'(m_tdata), 0);
        chk("rst_tlast",  32'(m_tlast), 0);
        chk("rst_busy",   32'(busy), 0);
        chk("rst_deq",    32'(fifo_deq), 0);
        occ = 0;
        stall = 1'b0;
      end else begin
        chk("deq_rule", 32'(fifo_deq), 32'(!fifo_empty && occ < 2));
        chk("tvalid",   32'(m_tvalid), 32'(occ != 0));
        chk("busy",     32'(busy), 32'(occ != 0));
        if (stall) begin
          chk("hold_data", 32'(m_tdata), 32'(pdata));
          chk("hold_last", 32'(m_tlast), 32'(plast));
        end
        mhs = (occ != 0) && m_tready;
        if (mhs) begin
          if (exq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%0h required=no_beat at %0t", m_tdata, $time);
          end else begin
            e = exq.pop_front();
            chk("tdata", 32'(m_tdata), 32'(e[W-1:0]));
            chk("tlast", 32'(m_tlast), 32'(e[W]));
          end
        end
        occ = occ + int'(fifo_deq) - int'(mhs);
        stall = m_tvalid && !m_tready;
        pdata = m_tdata;
        plast = m_tlast;
      end
    end
  end

  // Source for the PKT_LEN = 1 instance: three words 0x40.. after each reset.
  initial begin
    int   avail1;
    logic d;
    avail1 = 0;
    forever begin
      @(posedge clk);
      d = deq1;
      #1;
      if (!rst) begin
        avail1 = 3;
        dout1  = 8'h40;
      end else if (d && avail1 > 0) begin
        avail1--;
        dout1 = dout1 + 8'h01;
      end
      empty1 = (avail1 == 0);
    end
  end

  initial begin
    logic [W-1:0] exp1;
    exp1 = 8'h40;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp1 = 8'h40;
      end else if (tvalid1) begin
        chk("p1_tdata", 32'(tdata1), 32'(exp1));
        chk("p1_tlast", 32'(tlast1), 1);
        exp1 = exp1 + 8'h01;
        beats1++;
      end
    end
  end

  initial begin
    refresh();
    // Reset with a non-empty FIFO: nothing may be popped or presented.
    rst = 1'b0;
    fq.push_back(8'hAA);
    fq.push_back(8'hBB);
    refresh();
    for (int i = 0; i < 4; i++) step();
    clear_all();
    rst = 1'b1;
    step();

    // Streaming 0x10..0x17 with ready held high.
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    for (int i = 0; i < 12; i++) step();

    // Backpressure mid-burst.
    for (int i = 0; i < 6; i++) push(8'(8'h20 + i));
    step(); step();
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    m_tready = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // Alternating ready over 12 words.
    for (int i = 0; i < 12; i++) push(8'(8'h50 + i));
    for (int i = 0; i < 32; i++) begin
      m_tready = i[0];
      step();
    end
    m_tready = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // Reset in the middle of a packet, then a fresh packet.
    for (int i = 0; i < 4; i++) push(8'(8'h60 + i));
    step(); step(); step();
    do_reset(2);
    for (int i = 0; i < 4; i++) push(8'(8'h30 + i));
    for (int i = 0; i < 8; i++) step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 1 && fq.size() < 16) push(8'($urandom));
      m_tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        do_reset($urandom_range(1, 3));
      end
      step();
    end

    // Drain, bounded.
    m_tready = 1'b1;
    for (int i = 0; i < 200 && (exq.size() != 0 || fq.size() != 0); i++) step();
    step(); step();
    chk("drain_exq_left", 32'(exq.size()), 0);
    chk("drain_fifo_left", 32'(fq.size()), 0);
    chk("p1_beats_seen", 32'(beats1 >= 3), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_axis_tx.md
# fifo_axis_tx

Read-side adapter that drains the synchronous FIFO and presents its contents as an AXI4-Stream master. It sits between the FIFO's `dout`/`empty`/`deq` port and the downstream stream consumer. A 2-entry output buffer keeps `fifo_deq` free of any combinational path from `m_tready` while sustaining one beat per cycle. `m_tlast` is generated from a beat counter at fixed packet length.

## Interface
- `F_WIDTH`, default 8: data width; must match the FIFO.
- `PKT_LEN`, default 4: beats per packet; must be ≥ 1.
- `CW`, default derived: beat counter width; `$clog2(PKT_LEN)` when PKT_LEN > 1, else 1.

- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `fifo_dout`  input  F_WIDTH  FIFO head word; valid whenever `fifo_empty` is 0 (first-word fall-through).
- `fifo_empty`  input  1  FIFO empty flag.
- `fifo_deq`  output  1  pop request to the FIFO; the word on `fifo_dout` is captured in the same cycle.
- `m_tdata`  output  F_WIDTH  stream data.
- `m_tvalid`  output  1  stream valid.
- `m_tready`  input  1  stream ready from the consumer.
- `m_tlast`  output  1  last beat of the packet.
- `busy`  output  1  high when either buffer entry is occupied.

## Operation
- Storage consists of a main register (drives `m_tdata`/`m_tlast`) and a skid register, each holding data plus a last tag.
- Occupancy state machine: EMPTY(0), ONE(1), TWO(2). `m_tvalid` = (state != EMPTY). `busy` = `m_tvalid`.
- Handshake: `hs = m_tvalid & m_tready`.
- `fifo_deq = rst & !fifo_empty & (state != TWO)`. This depends only on registered state and `fifo_empty`, never on `m_tready`.
- EMPTY:
  - `fifo_deq` → ONE; main ← FIFO word.
  - Otherwise stay in EMPTY.
- ONE:
  - `hs & fifo_deq` → ONE; main ← FIFO word.
  - `hs & !fifo_deq` → EMPTY.
  - `!hs & fifo_deq` → TWO; skid ← FIFO word.
  - Neither → stay in ONE.
- TWO (`fifo_deq` = 0):
  - `hs` → ONE; main ← skid.
  - Otherwise stay in TWO.
- AXI stability: while `m_tvalid` is high and `m_tready` is low, `m_tdata`/`m_tlast` hold unchanged.
- Beat counter `cnt` (CW bits):
  - Advances on every `fifo_deq`.
  - Wraps from PKT_LEN-1 to 0.
  - The word captured gets last tag = (`cnt` == PKT_LEN-1).
  - With PKT_LEN = 1, every beat is last.
- Packet boundaries follow FIFO order exactly. No beat is dropped or duplicated.
- Reset (`rst` low, any time, asynchronous):
  - State → EMPTY; `cnt` → 0; main/skid data and tags → 0.
  - `m_tvalid`/`m_tlast`/`m_tdata`/`busy` → 0.
  - `fifo_deq` is forced 0 while `rst` is low.
  - In-flight beats are discarded. The FIFO shares `rst`, so both ends restart aligned at packet beat 0.

## Timing
- Latency: `fifo_empty` falls in cycle N with state EMPTY → `fifo_deq` = 1 in cycle N → `m_tvalid` = 1 with that word in cycle N+1.
- Throughput: with `m_tready` held 1 and the FIFO non-empty, one beat per cycle in steady state (state ONE).
- Backpressure: when `m_tready` drops, at most one extra word is popped (into skid). `fifo_deq` then stays 0 until a handshake returns the state to ONE.
- Recovery: from TWO, the first handshake moves to ONE. `fifo_deq` may assert in that same following cycle.
- Release from reset: first `fifo_deq` no earlier than the first rising edge with `rst` high. Outputs stay 0 until then.
- `m_tlast` is registered with `m_tdata`; no combinational input-to-output paths exist except `fifo_empty` → `fifo_deq`.

## Test plan
- Reset values: hold `rst` = 0 with FIFO non-empty → `fifo_deq` = 0, `m_tvalid` = 0, `m_tlast` = 0, `m_tdata` = 0, `busy` = 0.
- Streaming: PKT_LEN = 4, push 0x10..0x17 into the FIFO, `m_tready` = 1 → eight consecutive beats 0x10..0x17, first beat one cycle after `fifo_empty` falls; `m_tlast` on 0x13 and 0x17 only.
- Backpressure: stream 0x20..0x25, drop `m_tready` for 5 cycles mid-burst → exactly one extra pop occurs (state TWO, `fifo_deq` = 0); `m_tdata` is held stable; after release the order is intact with no loss or duplication.
- Alternating ready: `m_tready` toggling 1/0 every cycle over 12 words → all 12 delivered in order; `m_tlast` on every 4th beat; `fifo_deq` never asserted in state TWO.
- Reset mid-packet: assert `rst` after 2 beats of a 4-beat packet, refill with 0x30..0x33 → `m_tlast` on 0x33; counter restarted at 0.
- PKT_LEN = 1 build: stream 3 words → `m_tlast` = 1 on every beat.
